// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder
//   Pipelined ripple-carry adder/subtractor. The WIDTH-bit operands are cut
//   into NSEG = WIDTH/SEG segments. Stage k sums segment k and registers the
//   result together with the carry and the still-unsummed upper operand bits.
//   Latency is NSEG cycles and throughput is one operation per cycle. The
//   pipeline advances as a whole whenever the output slot is free or is being
//   drained.
//   WIDTH must be a multiple of SEG.
//
//   Optional feature macro: RCA_OVF_EN
//     When defined, ovf_o reports signed overflow.
//     When undefined, ovf_o is tied to 0.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset; flushes all in-flight ops
//   in_valid_i   operation presented
//   in_ready_o   operation accepted on an edge where in_valid_i && in_ready_o
//   a_i, b_i     operands (unsigned or two's complement)
//   cin_i        carry-in; ignored when sub_i=1
//   sub_i        1: a-b, 0: a+b+cin
//   out_valid_o  result present
//   out_ready_i  downstream accepts the result
//   s_o          sum / difference (modulo 2^WIDTH)
//   cout_o       carry out of the MSB; in subtract mode, 1 = no borrow
//   ovf_o        signed overflow (0 unless RCA_OVF_EN)
module pipelined_rca_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int NSEG = WIDTH / SEG;

  logic            advance;
  logic [NSEG-1:0] vld_pipe_q;

  // Global stall: every stage moves together, or none does.
  assign advance     = !out_valid_o || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = vld_pipe_q[NSEG-1];

  always_ff @(posedge clk_i) begin
    if (rst_i)        vld_pipe_q <= '0;
    else if (advance) vld_pipe_q <= (vld_pipe_q << 1) | NSEG'(in_valid_i);
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int WIN = WIDTH - k*SEG;   // operand bits not yet summed
    localparam int WLO = k*SEG;           // sum bits already produced

    logic [WIN-1:0]     a_in, b_in;
    logic               c_in;
    logic [SEG-1:0]     seg_sum;
    logic               c_out;
    logic [WLO+SEG-1:0] lo_d, lo_q;
    logic               c_q;

    if (k == 0) begin : g_first
      // Subtract is a + ~b + 1, so cin is overridden by sub.
      assign a_in = a_i;
      assign b_in = sub_i ? ~b_i : b_i;
      assign c_in = sub_i | cin_i;
      assign lo_d = seg_sum;
    end else begin : g_next
      assign a_in = g_stg[k-1].g_hi.ahi_q;
      assign b_in = g_stg[k-1].g_hi.bhi_q;
      assign c_in = g_stg[k-1].c_q;
      assign lo_d = {seg_sum, g_stg[k-1].lo_q};
    end

    assign {c_out, seg_sum} = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                              + (SEG+1)'(c_in);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lo_q <= '0;
        c_q  <= 1'b0;
      end else if (advance) begin
        lo_q <= lo_d;
        c_q  <= c_out;
      end
    end

    // Upper operand bits ride along until their segment is reached; the
    // operand sign bits travel here too and feed the overflow term.
    if (k < NSEG-1) begin : g_hi
      logic [WIN-SEG-1:0] ahi_q, bhi_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ahi_q <= '0;
          bhi_q <= '0;
        end else if (advance) begin
          ahi_q <= a_in[WIN-1:SEG];
          bhi_q <= b_in[WIN-1:SEG];
        end
      end
    end

`ifdef RCA_OVF_EN
    if (k == NSEG-1) begin : g_last
      logic ovf_d, ovf_q;
      // a^b'^s at the MSB recovers the carry into the MSB; overflow is that
      // carry differing from the carry out.
      assign ovf_d = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1] ^ c_out;
      always_ff @(posedge clk_i) begin
        if (rst_i)        ovf_q <= 1'b0;
        else if (advance) ovf_q <= ovf_d;
      end
      assign ovf_o = ovf_q;
    end
`endif
  end

`ifndef RCA_OVF_EN
  assign ovf_o = 1'b0;
`endif

  assign s_o    = g_stg[NSEG-1].lo_q;
  assign cout_o = g_stg[NSEG-1].c_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
module tb_pipelined_rca_adder;
  localparam int W  = 32;
  localparam int SG = 4;
  localparam int NS = W / SG;
`ifdef RCA_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        c, o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, 8-stage DUT
  logic        vin, irdy, ovld, ordy, cin_r, sub_r, cout, ovf;
  logic [31:0] a_r, b_r, s;
  // 8-bit, single-stage DUT
  logic        vin8, irdy8, ovld8, ordy8, cin8, sub8, cout8, ovf8;
  logic [7:0]  a8, b8, s8;

  pipelined_rca_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vin), .in_ready_o(irdy),
    .a_i(a_r), .b_i(b_r), .cin_i(cin_r), .sub_i(sub_r),
    .out_valid_o(ovld), .out_ready_i(ordy), .s_o(s), .cout_o(cout), .ovf_o(ovf));

  pipelined_rca_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vin8), .in_ready_o(irdy8),
    .a_i(a8), .b_i(b8), .cin_i(cin8), .sub_i(sub8),
    .out_valid_o(ovld8), .out_ready_i(ordy8), .s_o(s8), .cout_o(cout8), .ovf_o(ovf8));

  int   checks = 0, errors = 0, spurious = 0, cyc = 0;
  exp_t q[$], q8[$];
  exp_t me, me8;
  logic        stalled_prev = 1'b0;
  logic [31:0] s_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, b, input logic ci, sb);
    exp_t        m;
    logic [31:0] bp;
    logic [32:0] f;
    bp    = sb ? ~b : b;
    f     = {1'b0, a} + {1'b0, bp} + 33'(sb | ci);
    m.s   = f[31:0];
    m.c   = f[32];
    m.o   = OVF_ON & (a[31] == bp[31]) & (f[31] != a[31]);
    m.lat = 1'b0;
    m.acc = 0;
    return m;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, b, input logic ci, sb, input exp_t e);
    int n = 0;
    a_r = a; b_r = b; cin_r = ci; sub_r = sb; vin = 1'b1;
    @(negedge clk);
    while (!irdy && n < 200) begin @(negedge clk); n++; end
    if (!irdy) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", irdy);
    end else begin
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic        ci, sb;
    a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
    send(a, b, ci, sb, model(a, b, ci, sb));
  endtask

  task automatic send8(input logic [7:0] a, b, input logic ci, sb,
                       input logic [7:0] es, input logic ec, eo);
    exp_t e;
    int   n = 0;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; vin8 = 1'b1;
    @(negedge clk);
    while (!irdy8 && n < 50) begin @(negedge clk); n++; end
    e.s = {24'd0, es}; e.c = ec; e.o = eo & OVF_ON; e.lat = 1'b1; e.acc = cyc + 1;
    if (irdy8) q8.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL send8_timeout in_ready=%0b required=1", irdy8);
    end
    @(posedge clk); #1;
    vin8 = 1'b0;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 200) begin @(posedge clk); n++; end
    #1;
    chk("drain_left", 64'(q.size() + q8.size()), 64'd0);
  endtask

  // Scoreboard monitor for the 32-bit DUT.
  always @(negedge clk) begin
    if (!rst && ovld && ordy) begin
      stalled_prev = 1'b0;
      if (q.size() == 0) begin
        checks++; errors++; spurious++;
        $display("FAIL unexpected_result s=%0h required=no output", s);
      end else begin
        me = q.pop_front();
        chk("s",    64'(s),    64'(me.s));
        chk("cout", 64'(cout), 64'(me.c));
        chk("ovf",  64'(ovf),  64'(me.o));
        if (me.lat) chk("latency", 64'(cyc - me.acc), 64'(NS - 1));
      end
    end else if (!rst && ovld && !ordy) begin
      if (stalled_prev) chk("stall_s_stable", 64'(s), 64'(s_hold));
      chk("stall_in_ready", 64'(irdy), 64'd0);
      s_hold       = s;
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Scoreboard monitor for the single-stage DUT.
  always @(negedge clk) begin
    if (!rst && ovld8 && ordy8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result8 s=%0h required=no output", s8);
      end else begin
        me8 = q8.pop_front();
        chk("s8",       64'(s8),    64'(me8.s[7:0]));
        chk("cout8",    64'(cout8), 64'(me8.c));
        chk("ovf8",     64'(ovf8),  64'(me8.o));
        chk("latency8", 64'(cyc - me8.acc), 64'd0);
      end
    end
  end

  vec_t vt[10];
  exp_t e0;

  initial begin
    // Hand-computed: a, b, cin, sub, s, cout, ovf (ovf gated by OVF_ON)
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
    vt[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[6] = '{32'h0000000F, 32'h00000001, 1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0};
    vt[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[8] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vt[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst = 1'b1; vin = 1'b0; ordy = 1'b1; a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
    vin8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_during", 64'(irdy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(ovld), 64'd0);
    chk("rst_s",         64'(s),    64'd0);
    chk("rst_cout",      64'(cout), 64'd0);
    chk("rst_ovf",       64'(ovf),  64'd0);
    chk("rst_in_ready",  64'(irdy), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, first one latency-checked, with a 2-cycle bubble.
    for (int i = 0; i < 10; i++) begin
      e0.s = vt[i].s; e0.c = vt[i].c; e0.o = vt[i].o & OVF_ON;
      e0.lat = (i == 0); e0.acc = 0;
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e0);
      if (i == 3) idle(2);
    end
    drain();

    // 16 back-to-back operations against the reference model.
    for (int i = 0; i < 16; i++) send_rand();
    drain();

    // Back-pressure: hold out_ready low for 5 cycles mid-stream.
    fork
      begin : g_stream
        for (int i = 0; i < 12; i++) send_rand();
      end
      begin : g_stall
        int n = 0;
        while (!ovld && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ordy = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        ordy = 1'b1;
      end
    join
    drain();

    // Reset with 4 operations in flight: all of them must vanish.
    for (int i = 0; i < 4; i++) send_rand();
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(ovld), 64'd0);
    chk("midrst_s",         64'(s),    64'd0);
    chk("midrst_in_ready",  64'(irdy), 64'd1);
    @(posedge clk); #1;
    idle(15);
    chk("midrst_no_stale", 64'(spurious), 64'd0);
    send(32'h00000003, 32'h00000004, 1'b0, 1'b0, model(32'h3, 32'h4, 1'b0, 1'b0));
    drain();

    // Single-stage configuration.
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    send8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
